// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int OFFSET_W       = $clog2(BYTES_PER_WORD);
  localparam int CNT_W          = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-enabled write and strobed registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      acc_en,
  input  logic                      acc_write,
  input  logic [IDX_W-1:0]          acc_idx,
  input  logic [DATA_W-1:0]         acc_wdata,
  input  logic [BYTES_PER_WORD-1:0] acc_be,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] wr_word_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    wr_word_d = mem_q[acc_idx];
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (acc_be[b]) begin
        wr_word_d[8*b +: 8] = acc_wdata[8*b +: 8];
      end
    end
    // Read data lives for one cycle only, so it is zero outside the response.
    rdata_d = (acc_en && !acc_write) ? mem_q[acc_idx] : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (acc_en && acc_write) begin
        mem_q[acc_idx] <= wr_word_d;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store target for the pipeline MEM stage
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int                IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              fire;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [3:0]        acc_be;
  logic              acc_err;

  assign accept = req_valid && req_ready_q;

  // Outside WAIT the access can only come from a LATENCY=1 accept, which uses the live request.
  always_comb begin
    if (state_q == WAIT) begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end else begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
    acc_err = (acc_addr[OFFSET_W-1:0] != '0) || ((acc_addr >> OFFSET_W) >= DEPTH_L);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    fire    = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 1) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          fire    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    resp_valid_d = fire;
    resp_err_d   = fire && acc_err;
    busy_d       = (state_d == WAIT);
    req_ready_d  = (state_d != WAIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .acc_en    (fire && !acc_err),
    .acc_write (acc_write),
    .acc_idx   (acc_addr[OFFSET_W +: IDX_W]),
    .acc_wdata (acc_wdata),
    .acc_be    (acc_be),
    .rdata     (resp_rdata)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        ready2, valid2, err2, busy2;
  logic [31:0] rdata2;
  logic        ready1, valid1, err1, busy1;
  logic [31:0] rdata1;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  int checks = 0, errors = 0, issued2 = 0, resp_cnt2 = 0;
  vec_t        vecs[14];
  logic [31:0] b2b[4];

  always #5 clock = ~clock;

  dmem_responder #(.LATENCY(2)) u_lat2 (
    .clock(clock), .reset(reset), .req_valid(req_valid && !sel), .req_ready(ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(valid2), .resp_rdata(rdata2), .resp_err(err2), .busy(busy2)
  );

  dmem_responder #(.LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset), .req_valid(req_valid && sel), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(valid1), .resp_rdata(rdata1), .resp_err(err1), .busy(busy1)
  );

  assign req_ready  = sel ? ready1 : ready2;
  assign resp_valid = sel ? valid1 : valid2;
  assign resp_err   = sel ? err1   : err2;
  assign busy       = sel ? busy1  : busy2;
  assign resp_rdata = sel ? rdata1 : rdata2;

  always @(negedge clock) if (valid2 === 1'b1) resp_cnt2++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic s, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    int n;
    lat = s ? 1 : 2;
    n   = 0;
    @(negedge clock);
    sel = s; req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    if (!s) issued2++;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      if (k < lat) begin
        chk("wait_valid", 32'(resp_valid), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_ready", 32'(req_ready), 32'd0);
      end else begin
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_busy", 32'(busy), 32'd0);
      end
    end
    @(negedge clock);
    chk("after_valid", 32'(resp_valid), 32'd0);
    chk("after_rdata", resp_rdata, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b1, 32'h0,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'h4,   32'h01020304, 4'h8, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h4,   32'h0,        4'h0, 32'h01000000, 1'b0};
    b2b[0] = 32'h10203040; b2b[1] = 32'h50607080; b2b[2] = 32'h90A0B0C0; b2b[3] = 32'hD0E0F001;

    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_req(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Back-to-back loads with LATENCY=1
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 1'b1, 32'(i * 4), b2b[i], 4'hF, 32'h0, 1'b0);
    end
    @(negedge clock);
    sel = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_be = 4'h0; req_addr = 32'h0;
    chk("b2b_ready_pre", 32'(req_ready), 32'd1);
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("b2b_valid", 32'(resp_valid), 32'd1);
      chk("b2b_rdata", resp_rdata, b2b[i]);
      chk("b2b_ready", 32'(req_ready), 32'd1);
      if (i < 3) req_addr = 32'((i + 1) * 4);
      else req_valid = 1'b0;
    end
    @(negedge clock);
    chk("b2b_after_valid", 32'(resp_valid), 32'd0);

    // Request held during WAIT is taken only in the RESP cycle
    @(negedge clock);
    sel = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h55AA55AA; req_be = 4'hF;
    chk("hold_ready0", 32'(req_ready), 32'd1);
    issued2 += 2;
    @(negedge clock);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_ready_wait", 32'(req_ready), 32'd0);
    req_write = 1'b0; req_wdata = 32'h0; req_be = 4'h0;
    @(negedge clock);
    chk("hold_st_valid", 32'(resp_valid), 32'd1);
    chk("hold_st_rdata", resp_rdata, 32'd0);
    chk("hold_ready_resp", 32'(req_ready), 32'd1);
    @(negedge clock);
    chk("hold_ld_wait", 32'(resp_valid), 32'd0);
    chk("hold_ld_busy", 32'(busy), 32'd1);
    req_valid = 1'b0;
    @(negedge clock);
    chk("hold_ld_valid", 32'(resp_valid), 32'd1);
    chk("hold_ld_rdata", resp_rdata, 32'h55AA55AA);
    @(negedge clock);
    chk("hold_after", 32'(resp_valid), 32'd0);

    // Reset during WAIT aborts the store
    @(negedge clock);
    sel = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy_rst", 32'(busy), 32'd0);
    chk("abort_ready_rst", 32'(req_ready), 32'd1);
    chk("abort_valid_rst", 32'(resp_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    @(negedge clock);
    chk("resp_count", 32'(resp_cnt2), 32'(issued2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
